// File: rtl/mem_stage.sv
// Memory pipeline stage: NONE passthrough, misalignment detection, and a single
// outstanding load/store on a req/ack bus with sign-extended load writeback.
module mem_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic [DATA_W-1:0]     in_rd_data,
    input  logic [2:0]            in_mem_op,
    input  logic [DATA_W-1:0]     in_mem_data,
    output logic                  stall,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_W-1:0]     bus_addr,
    output logic [3:0]            bus_be,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_ack,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_rd_addr,
    output logic [DATA_W-1:0]     wb_rd_data,
    output logic                  misaligned
);

    localparam int unsigned OP_W = 3;
    localparam int unsigned BE_W = 4;

    localparam logic [OP_W-1:0] OP_NONE = 3'd0;
    localparam logic [OP_W-1:0] OP_LB   = 3'd1;
    localparam logic [OP_W-1:0] OP_LH   = 3'd2;
    localparam logic [OP_W-1:0] OP_LW   = 3'd3;
    localparam logic [OP_W-1:0] OP_SB   = 3'd4;
    localparam logic [OP_W-1:0] OP_SH   = 3'd5;
    localparam logic [OP_W-1:0] OP_SW   = 3'd6;

    typedef enum logic [0:0] {IDLE, BUSY} state_e;

    state_e                  state_q, state_d;
    logic [OP_W-1:0]         op_q, op_d;
    logic [REG_ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [1:0]              lane_q, lane_d;
    logic                    bus_req_q, bus_req_d;
    logic                    bus_we_q, bus_we_d;
    logic [DATA_W-1:0]       bus_addr_q, bus_addr_d;
    logic [BE_W-1:0]         bus_be_q, bus_be_d;
    logic [DATA_W-1:0]       bus_wdata_q, bus_wdata_d;
    logic                    wb_we_q, wb_we_d;
    logic [REG_ADDR_W-1:0]   wb_rd_addr_q, wb_rd_addr_d;
    logic [DATA_W-1:0]       wb_rd_data_q, wb_rd_data_d;
    logic                    misaligned_q, misaligned_d;

    logic                    in_is_load_c, in_is_store_c, in_is_mem_c, in_mis_c;
    logic                    ack_c, accept_c, start_c, load_done_c;
    logic [7:0]              lb_byte;
    logic [15:0]             lh_half;
    logic [DATA_W-1:0]       load_val;

    assign in_is_load_c  = (in_mem_op == OP_LB) || (in_mem_op == OP_LH) || (in_mem_op == OP_LW);
    assign in_is_store_c = (in_mem_op == OP_SB) || (in_mem_op == OP_SH) || (in_mem_op == OP_SW);
    assign in_is_mem_c   = in_is_load_c || in_is_store_c;
    assign in_mis_c      = (((in_mem_op == OP_LH) || (in_mem_op == OP_SH)) && in_rd_data[0])
                        || (((in_mem_op == OP_LW) || (in_mem_op == OP_SW)) && (in_rd_data[1:0] != 2'b00));

    // A new op is evaluated in IDLE or on the edge that completes the current transaction.
    assign ack_c       = (state_q == BUSY) && bus_ack;
    assign accept_c    = (state_q == IDLE) || ack_c;
    assign start_c     = accept_c && in_is_mem_c && !in_mis_c;
    assign load_done_c = ack_c && ((op_q == OP_LB) || (op_q == OP_LH) || (op_q == OP_LW));

    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;
    assign wb_we      = wb_we_q;
    assign wb_rd_addr = wb_rd_addr_q;
    assign wb_rd_data = wb_rd_data_q;
    assign misaligned = misaligned_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: an ack with a new aligned op chains straight into another transaction.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_c) state_d = BUSY;
            BUSY:    if (bus_ack) state_d = start_c ? BUSY : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Selected load lane, sign-extended to the data width.
    always_comb begin
        load_val = bus_rdata;
        lb_byte  = 8'(bus_rdata >> {lane_q, 3'b000});
        lh_half  = lane_q[1] ? 16'(bus_rdata >> 16) : 16'(bus_rdata);
        case (op_q)
            OP_LB:   load_val = {{(DATA_W-8){lb_byte[7]}}, lb_byte};
            OP_LH:   load_val = {{(DATA_W-16){lh_half[15]}}, lh_half};
            default: load_val = bus_rdata;
        endcase
    end

    // FSM outputs: stall, bus request setup, writeback and fault pulse.
    // A completing load owns the writeback port on its ack edge.
    always_comb begin
        op_d         = op_q;
        rd_addr_d    = rd_addr_q;
        lane_d       = lane_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        wb_we_d      = 1'b0;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_rd_data_d = wb_rd_data_q;
        misaligned_d = 1'b0;
        stall        = 1'b0;

        if (rst_n) begin
            stall = (state_q == BUSY) ? !bus_ack : start_c;
        end

        if (ack_c) begin
            bus_req_d = 1'b0;
            if (load_done_c) begin
                wb_we_d      = (rd_addr_q != '0);
                wb_rd_addr_d = rd_addr_q;
                wb_rd_data_d = load_val;
            end
        end

        if (accept_c) begin
            if (!in_is_mem_c) begin
                if (!load_done_c) begin
                    wb_we_d      = (in_rd_addr != '0);
                    wb_rd_addr_d = in_rd_addr;
                    wb_rd_data_d = in_rd_data;
                end
            end else if (in_mis_c) begin
                misaligned_d = 1'b1;
            end else begin
                op_d       = in_mem_op;
                rd_addr_d  = in_rd_addr;
                lane_d     = in_rd_data[1:0];
                bus_req_d  = 1'b1;
                bus_we_d   = in_is_store_c;
                bus_addr_d = {in_rd_data[DATA_W-1:2], 2'b00};
                case (in_mem_op)
                    OP_LB, OP_SB: bus_be_d = BE_W'(4'b0001 << in_rd_data[1:0]);
                    OP_LH, OP_SH: bus_be_d = BE_W'(4'b0011 << in_rd_data[1:0]);
                    default:      bus_be_d = BE_W'(4'b1111);
                endcase
                case (in_mem_op)
                    OP_SB:   bus_wdata_d = DATA_W'({4{in_mem_data[7:0]}});
                    OP_SH:   bus_wdata_d = DATA_W'({2{in_mem_data[15:0]}});
                    default: bus_wdata_d = in_mem_data;
                endcase
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q         <= OP_NONE;
            rd_addr_q    <= '0;
            lane_q       <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            wb_we_q      <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_rd_data_q <= '0;
            misaligned_q <= 1'b0;
        end else begin
            op_q         <= op_d;
            rd_addr_q    <= rd_addr_d;
            lane_q       <= lane_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            wb_we_q      <= wb_we_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_rd_data_q <= wb_rd_data_d;
            misaligned_q <= misaligned_d;
        end
    end

endmodule
